fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares one `FifoMem` write port (8-bit, 16-deep) among `N_REQ` producers. Each producer offers data through a valid/ready handshake. The arbiter grants one owner at a time, steers its data onto `fifo_din`/`fifo_wr`, honours `fifo_full` back-pressure and latches FIFO overflow as a sticky error. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: data width; must equal the FIFO data width.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1. Used only when `FIFO_ARB_BURST_EN` is defined.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `N_REQ`: per-requester data valid.
- `req_data` in `N_REQ*DW`: requester i occupies bits `[i*DW +: DW]`.
- `req_ready` out `N_REQ`: per-requester accept; a beat transfers when valid & ready.
- `fifo_wr` out 1: FIFO write strobe; drives `FifoMem` `wr`.
- `fifo_din` out `DW`: FIFO write data; drives `FifoMem` `data_in`.
- `fifo_full` in 1: from `FifoMem`.
- `fifo_overflow` in 1: from `FifoMem`.
- `grant_id` out `$clog2(N_REQ)`: current owner index; valid when `busy`=1.
- `busy` out 1: 1 in state OWN.
- `err_overflow` out 1: sticky overflow flag.

## Operation
- Registered state: `state` (IDLE/OWN), `owner`, `last` (round-robin pointer), `beat_cnt` (`$clog2(MAX_BURST+1)` bits), `err_overflow`.
- Round-robin search order is `last+1`, `last+2`, … , `last`, modulo `N_REQ`. The previous owner therefore has the lowest priority, but it can win when it is the only requester.
- IDLE:
  - `req_ready`=0 and `fifo_wr`=0.
  - If any `req_valid` is set, the search winner is registered as `owner`: state becomes OWN, `beat_cnt`=0, `last`=winner.
- OWN:
  - `req_ready[owner]` = `req_valid[owner]` & ~`fifo_full`. All other ready bits are 0.
  - `fifo_wr` = `req_valid[owner]` & `req_ready[owner]`. `fifo_din` = owner's data, combinationally.
  - An accepted beat increments `beat_cnt`.
  - Exit occurs when (a) a beat is accepted and `beat_cnt+1`==`MAX_BURST`, or (b) `req_valid[owner]`=0.
  - On exit, the search runs in the same cycle with `last`=owner. If any requester is valid, it becomes the new owner with no bubble. Otherwise state returns to IDLE.
- Back-pressure: while `fifo_full`=1, no beat is accepted, `beat_cnt` is held, and there is no exit unless the owner's valid drops.
- Requesters must hold valid and data stable until ready. A valid drop before acceptance is treated as exit (b).
- `err_overflow` is set on any cycle with `fifo_overflow`=1. Only reset clears it.

## Timing
- Reset values:
  - state IDLE, `owner`=0, `last`=`N_REQ-1` (requester 0 wins first), `beat_cnt`=0, `err_overflow`=0.
  - `busy`=0, `grant_id`=0.
- While `rst_n`=0, `req_ready` and `fifo_wr` are forced to 0 combinationally.
- Latency from IDLE: valid at cycle t gives grant, ready and `fifo_wr` at cycle t+1.
- Handover within OWN has zero bubble cycles.
- Throughput is 1 beat/cycle when the FIFO is not full.
- `fifo_wr` is combinational from the registered owner and the current `fifo_full`. The FIFO updates `full` after the write edge, so the arbiter never writes into a full FIFO.
- Reset mid-burst: the in-flight beat in the reset cycle is not written. The next cycle is IDLE with the reset pointer.
- `grant_id` and `busy` are registered.

## Configuration
- `FIFO_ARB_BURST_EN` defined: the grant is held for up to `MAX_BURST` beats as described above.
- `FIFO_ARB_BURST_EN` undefined: the effective `MAX_BURST` is 1. Every accepted beat forces exit and re-arbitration, giving strict per-beat round-robin. The `beat_cnt` logic is removed.

## Test plan
- Reset, then req1 alone streams 0x11..0x16 (burst on):
  - IDLE for 1 cycle, then `grant_id`=1.
  - 6 consecutive `fifo_wr` pulses, data in order.
  - Re-grant to req1 after beat 4 with no bubble.
- All 4 requesters continuously valid (burst on, `MAX_BURST`=4): grant sequence is 0,1,2,3,0, 4 beats each, `fifo_wr` high every cycle until full. With the macro off, owners rotate 0,1,2,3,0 one beat each.
- `fifo_full`=1 for 3 cycles after beat 2 of req2's burst:
  - `fifo_wr`=0 and `req_ready`=0 for those cycles, `grant_id` stays 2.
  - Beats 3–4 complete afterwards, then handover.
- req0 drops valid after 2 beats while req3 is valid: next cycle `grant_id`=3 with `fifo_wr`=1, no idle cycle.
- One-cycle `fifo_overflow` pulse: `err_overflow`=1 from the next cycle and stays 1 until `rst_n`=0.
- `rst_n` low for 1 cycle during req3 beat 2:
  - `fifo_wr`=0 in the reset cycle.
  - Then IDLE, and with all requesters valid, req0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter in front of a single FIFO write port. N_REQ
// producers offer beats through valid/ready. One owner at a time is granted,
// and its data is steered onto fifo_din/fifo_wr. fifo_full back-pressure is
// honoured, and FIFO overflow is latched as a sticky error.
//
// Configuration macro:
//   FIFO_ARB_BURST_EN  defined   : a grant lasts up to MAX_BURST accepted beats.
//                      undefined : a grant lasts one beat (strict per-beat
//                                  round-robin). The beat counter is absent.
//
// Parameters:
//   N_REQ      number of requesters (2..8)
//   DW         data width (equal to the FIFO data width)
//   MAX_BURST  beats per grant when FIFO_ARB_BURST_EN is defined (>= 1)
//
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   req_valid      per-requester valid
//   req_data       requester i data at [i*DW +: DW]
//   req_ready      per-requester accept (beat moves on valid & ready)
//   fifo_wr        FIFO write strobe
//   fifo_din       FIFO write data
//   fifo_full      FIFO full flag
//   fifo_overflow  FIFO overflow flag
//   grant_id       current owner index (meaningful while busy)
//   busy           arbiter holds a grant (state OWN)
//   err_overflow   sticky overflow error, cleared only by reset
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_wr,
  output logic [DW-1:0]              fifo_din,
  input  logic                       fifo_full,
  input  logic                       fifo_overflow,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err_overflow
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   owner_reg, owner_next;
  logic [GW-1:0]   last_reg, last_next;
  logic            err_reg, err_next;

`ifdef FIFO_ARB_BURST_EN
  localparam int BCW = $clog2(MAX_BURST + 1);
  logic [BCW-1:0]  beat_cnt_reg, beat_cnt_next;
`else
  // In single-beat mode MAX_BURST has no effect. It is referenced here so that
  // the parameter remains part of the interface.
  logic [31:0]     unused_max_burst;
  assign unused_max_burst = MAX_BURST;
`endif

  // ---------------------------------------------------------------------------
  // Per-requester data slices
  // ---------------------------------------------------------------------------
  logic [DW-1:0] data_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester after ptr, wrapping back to ptr
  // itself. The loop runs from the farthest candidate to the nearest, so the
  // nearest valid candidate is the last one written and therefore wins.
  // ---------------------------------------------------------------------------
  function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [GW-1:0]    ptr);
    logic [GW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (v[idx]) pick = GW'(idx);
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic          owner_valid;
  logic          accept;       // owner beat moves this cycle
  logic          burst_done;   // the accepted beat is the last of this grant
  logic          leave;        // OWN ends this cycle
  logic          any_valid;
  logic [GW-1:0] search_ptr;
  logic [GW-1:0] winner;

  assign owner_valid = req_valid[owner_reg];
  assign accept      = (state_reg == OWN) && owner_valid && !fifo_full;
  assign any_valid   = |req_valid;

`ifdef FIFO_ARB_BURST_EN
  assign burst_done  = (beat_cnt_reg == BCW'(MAX_BURST - 1));
`else
  assign burst_done  = 1'b1;
`endif

  // A valid drop ends the grant even if no beat moved. While full, the owner
  // keeps its grant as long as it stays valid.
  assign leave = (state_reg == OWN) && ((accept && burst_done) || !owner_valid);

  // On handover the outgoing owner becomes the pointer, so it has the lowest
  // priority in the same-cycle search. In OWN, last_reg already equals owner_reg.
  assign search_ptr = (state_reg == OWN) ? owner_reg : last_reg;
  assign winner     = rr_pick(req_valid, search_ptr);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      last_reg     <= GW'(N_REQ - 1);
      err_reg      <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      err_reg      <= err_next;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_reg <= beat_cnt_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    err_next      = err_reg | fifo_overflow;
`ifdef FIFO_ARB_BURST_EN
    beat_cnt_next = beat_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next    = OWN;
          owner_next    = winner;
          last_next     = winner;
`ifdef FIFO_ARB_BURST_EN
          beat_cnt_next = '0;
`endif
        end
      end

      OWN: begin
`ifdef FIFO_ARB_BURST_EN
        if (accept) beat_cnt_next = beat_cnt_reg + BCW'(1);
`endif
        if (leave) begin
          last_next = owner_reg;
          if (any_valid) begin
            // Zero-bubble handover. The outgoing owner can win again only
            // when it is the sole valid requester.
            state_next    = OWN;
            owner_next    = winner;
            last_next     = winner;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt_next = '0;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. The write strobe and ready are combinational from the registered
  // owner and the current fifo_full. As a result, no beat is written in a
  // cycle where the FIFO is already full. Reset masks them in the same cycle,
  // so an in-flight beat is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_din  = data_arr[owner_reg];
    if (rst_n && accept) begin
      req_ready[owner_reg] = 1'b1;
      fifo_wr              = 1'b1;
    end
  end

  assign busy         = (state_reg == OWN);
  assign grant_id     = owner_reg;
  assign err_overflow = err_reg;

endmodule
